// File: rtl/kronos_wb.sv
// rtl/kronos_wb.sv - write-back stage: register write, branch redirect, load/store and system routing

package kronos_wb_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result1;
    logic [31:0] result2;
    logic [4:0]  rd;
    logic        rd_write;
    logic        branch;
    logic        branch_cond;
    logic        ld;
    logic        st;
    logic [2:0]  funct3;
    logic        csr;
    logic        ecall;
    logic        ret;
    logic        wfi;
    logic        is_illegal;
  } pipeEXWB_t;
endpackage

module kronos_wb
  import kronos_wb_pkg::*;
#(
  parameter int unsigned MISALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rstz,
  input  pipeEXWB_t   execute,
  input  logic        execute_vld,
  output logic        execute_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_ack,
  input  logic [31:0] data_rd_data,
  output logic        sys_req,
  output logic [1:0]  sys_cause,
  output logic [31:0] sys_pc,
  input  logic        sys_ack
);

  typedef enum logic [1:0] {STEADY, MEM, SYS} state_t;

  state_t      state_q, state_d;
  logic        regwr_en_q, regwr_en_d;
  logic [31:0] regwr_data_q, regwr_data_d;
  logic [4:0]  regwr_sel_q, regwr_sel_d;
  logic        branch_q, branch_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wr_data_q, data_wr_data_d;
  logic [3:0]  data_mask_q, data_mask_d;
  logic        data_wr_en_q, data_wr_en_d;
  logic        data_req_q, data_req_d;
  logic        sys_req_q, sys_req_d;
  logic [1:0]  sys_cause_q, sys_cause_d;
  logic [31:0] sys_pc_q, sys_pc_d;
  // pending load bookkeeping, consumed when the memory acknowledges
  logic        is_ld_q, is_ld_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [4:0]  ld_rd_q, ld_rd_d;

  logic        accept;
  logic [1:0]  acc_size, acc_off, eff_off;
  logic        misaligned;
  logic [3:0]  acc_mask;
  logic [31:0] st_data, ld_shift, ld_data;

  assign execute_rdy = (state_q == STEADY);
  assign accept      = execute_vld & execute_rdy;

  // Decode access size, byte lanes and store data for the incoming ld/st.
  // Half accesses on an odd byte (only reachable with the check disabled)
  // fall back to the enclosing aligned half; words to the whole word.
  always_comb begin
    acc_size   = execute.funct3[1:0];
    acc_off    = execute.result1[1:0];
    misaligned = ((acc_size == 2'b01) & acc_off[0]) |
                 ((acc_size == 2'b10) & (acc_off != 2'b00));
    eff_off    = 2'b00;
    acc_mask   = 4'b1111;
    st_data    = execute.result2;
    case (acc_size)
      2'b00: begin
        eff_off  = acc_off;
        acc_mask = 4'b0001 << eff_off;
        st_data  = {4{execute.result2[7:0]}};
      end
      2'b01: begin
        eff_off  = {acc_off[1], 1'b0};
        acc_mask = 4'b0011 << eff_off;
        st_data  = {2{execute.result2[15:0]}};
      end
      default: begin
        eff_off  = 2'b00;
        acc_mask = 4'b1111;
        st_data  = execute.result2;
      end
    endcase
  end

  // Extract the addressed lane of returned load data and extend it.
  always_comb begin
    ld_shift = data_rd_data >> {ld_off_q, 3'b000};
    case (ld_funct3_q[1:0])
      2'b00:   ld_data = ld_funct3_q[2] ? {24'b0, ld_shift[7:0]}
                                        : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = ld_funct3_q[2] ? {16'b0, ld_shift[15:0]}
                                        : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = data_rd_data;
    endcase
  end

  // Next-state and output decisions; strobes default low, payloads hold.
  always_comb begin
    state_d         = state_q;
    regwr_en_d      = 1'b0;
    regwr_data_d    = regwr_data_q;
    regwr_sel_d     = regwr_sel_q;
    branch_d        = 1'b0;
    branch_target_d = branch_target_q;
    data_addr_d     = data_addr_q;
    data_wr_data_d  = data_wr_data_q;
    data_mask_d     = data_mask_q;
    data_wr_en_d    = data_wr_en_q;
    data_req_d      = data_req_q;
    sys_req_d       = sys_req_q;
    sys_cause_d     = sys_cause_q;
    sys_pc_d        = sys_pc_q;
    is_ld_d         = is_ld_q;
    ld_funct3_d     = ld_funct3_q;
    ld_off_d        = ld_off_q;
    ld_rd_d         = ld_rd_q;
    case (state_q)
      STEADY: begin
        if (accept) begin
          if (execute.is_illegal) begin
            state_d     = SYS;
            sys_req_d   = 1'b1;
            sys_cause_d = 2'd3;
            sys_pc_d    = execute.pc;
          end else if (execute.csr | execute.ecall | execute.ret | execute.wfi) begin
            state_d     = SYS;
            sys_req_d   = 1'b1;
            sys_cause_d = 2'd0;
            sys_pc_d    = execute.pc;
          end else if ((execute.ld | execute.st) & misaligned & (MISALIGN_CHECK != 0)) begin
            state_d     = SYS;
            sys_req_d   = 1'b1;
            sys_cause_d = execute.ld ? 2'd1 : 2'd2;
            sys_pc_d    = execute.pc;
          end else if (execute.ld | execute.st) begin
            state_d        = MEM;
            data_req_d     = 1'b1;
            data_addr_d    = {execute.result1[31:2], 2'b00};
            data_mask_d    = acc_mask;
            data_wr_en_d   = ~execute.ld;
            data_wr_data_d = st_data;
            is_ld_d        = execute.ld;
            ld_funct3_d    = execute.funct3;
            ld_off_d       = eff_off;
            ld_rd_d        = execute.rd;
          end else if (execute.branch_cond) begin
            branch_d        = execute.result1[0];
            branch_target_d = execute.result2;
          end else begin
            regwr_en_d   = execute.rd_write & (execute.rd != 5'd0);
            regwr_data_d = execute.result1;
            regwr_sel_d  = execute.rd;
            if (execute.branch) begin
              branch_d        = 1'b1;
              branch_target_d = execute.result2;
            end
          end
        end
      end
      MEM: begin
        if (data_ack) begin
          state_d    = STEADY;
          data_req_d = 1'b0;
          if (is_ld_q & (ld_rd_q != 5'd0)) begin
            regwr_en_d   = 1'b1;
            regwr_data_d = ld_data;
            regwr_sel_d  = ld_rd_q;
          end
        end
      end
      SYS: begin
        if (sys_ack) begin
          state_d   = STEADY;
          sys_req_d = 1'b0;
        end
      end
      default: state_d = STEADY;
    endcase
  end

  // State and output registers; reset abandons any pending operation.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q         <= STEADY;
      regwr_en_q      <= 1'b0;
      regwr_data_q    <= '0;
      regwr_sel_q     <= '0;
      branch_q        <= 1'b0;
      branch_target_q <= '0;
      data_addr_q     <= '0;
      data_wr_data_q  <= '0;
      data_mask_q     <= '0;
      data_wr_en_q    <= 1'b0;
      data_req_q      <= 1'b0;
      sys_req_q       <= 1'b0;
      sys_cause_q     <= '0;
      sys_pc_q        <= '0;
      is_ld_q         <= 1'b0;
      ld_funct3_q     <= '0;
      ld_off_q        <= '0;
      ld_rd_q         <= '0;
    end else begin
      state_q         <= state_d;
      regwr_en_q      <= regwr_en_d;
      regwr_data_q    <= regwr_data_d;
      regwr_sel_q     <= regwr_sel_d;
      branch_q        <= branch_d;
      branch_target_q <= branch_target_d;
      data_addr_q     <= data_addr_d;
      data_wr_data_q  <= data_wr_data_d;
      data_mask_q     <= data_mask_d;
      data_wr_en_q    <= data_wr_en_d;
      data_req_q      <= data_req_d;
      sys_req_q       <= sys_req_d;
      sys_cause_q     <= sys_cause_d;
      sys_pc_q        <= sys_pc_d;
      is_ld_q         <= is_ld_d;
      ld_funct3_q     <= ld_funct3_d;
      ld_off_q        <= ld_off_d;
      ld_rd_q         <= ld_rd_d;
    end
  end

  assign regwr_en      = regwr_en_q;
  assign regwr_data    = regwr_data_q;
  assign regwr_sel     = regwr_sel_q;
  assign branch        = branch_q;
  assign branch_target = branch_target_q;
  assign data_addr     = data_addr_q;
  assign data_wr_data  = data_wr_data_q;
  assign data_mask     = data_mask_q;
  assign data_wr_en    = data_wr_en_q;
  assign data_req      = data_req_q;
  assign sys_req       = sys_req_q;
  assign sys_cause     = sys_cause_q;
  assign sys_pc        = sys_pc_q;

endmodule
